muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 12 +
 rtl/muldiv_div_step.sv | 17 +
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings and FSM state for the iterative multiply/divide unit
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one restoring-division iteration on unsigned magnitudes
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);
  logic [WIDTH:0] sh, df;
  assign sh = {rem, quo[WIDTH-1]};
  assign df = sh - {1'b0, dvs};
  // a borrow out of the subtract means restore the shifted remainder
  assign rem_n = df[WIDTH] ? sh[WIDTH-1:0] : df[WIDTH-1:0];
  assign quo_n = {quo[WIDTH-2:0], ~df[WIDTH]};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO registers.
// The divider and DIV/DIVU are built only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_sel,
  output logic [WIDTH-1:0] rd,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, p_hi, p_lo, md;
  logic             neg_q;
  logic             is_mul, is_dv, is_sgn, sa, sb;
  logic [WIDTH-1:0] ma, mb, c_hi, c_lo, f_hi, f_lo;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod, prod_s;
`ifdef MULDIV_DIV_EN
  logic             is_div, neg_r, dz;
  logic [WIDTH-1:0] a_q, d_rem, d_quo;
  muldiv_div_step #(.WIDTH(WIDTH)) u_step (
    .rem  (p_hi),
    .quo  (p_lo),
    .dvs  (md),
    .rem_n(d_rem),
    .quo_n(d_quo)
  );
  assign is_dv = op == OP_DIV || op == OP_DIVU;
`else
  assign is_dv = 1'b0;
`endif
  assign is_mul = op == OP_MULT || op == OP_MULTU;
  assign is_sgn = op == OP_MULT || op == OP_DIV;
  assign sa = is_sgn & a[WIDTH-1];
  assign sb = is_sgn & b[WIDTH-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign rd = hi_sel ? hi : lo;
  // p_hi:p_lo is accumulator:multiplier for multiply, remainder:quotient for divide
  always_comb begin
    sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, md} : '0);
    prod = {p_hi, p_lo};
    prod_s = neg_q ? -prod : prod;
`ifdef MULDIV_DIV_EN
    c_hi = is_div ? d_rem : sum[WIDTH:1];
    c_lo = is_div ? d_quo : {sum[0], p_lo[WIDTH-1:1]};
    f_hi = !is_div ? prod_s[2*WIDTH-1:WIDTH] : dz ? a_q : neg_r ? -p_hi : p_hi;
    f_lo = !is_div ? prod_s[WIDTH-1:0] : dz ? '1 : neg_q ? -p_lo : p_lo;
`else
    c_hi = sum[WIDTH:1];
    c_lo = {sum[0], p_lo[WIDTH-1:1]};
    f_hi = prod_s[2*WIDTH-1:WIDTH];
    f_lo = prod_s[WIDTH-1:0];
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      p_hi  <= '0;
      p_lo  <= '0;
      md    <= '0;
      neg_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      a_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            if (op == OP_MTHI) hi <= a;
            else if (op == OP_MTLO) lo <= a;
            else if (is_mul || is_dv) begin
              state <= CALC;
              busy  <= 1'b1;
              cnt   <= '0;
              p_hi  <= '0;
              p_lo  <= is_dv ? ma : mb;
              md    <= is_dv ? mb : ma;
              neg_q <= sa ^ sb;
`ifdef MULDIV_DIV_EN
              is_div <= is_dv;
              neg_r  <= sa;
              dz     <= b == '0;
              a_q    <= a;
`endif
            end
          end
          CALC: begin
            p_hi <= c_hi;
            p_lo <= c_lo;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
          FIX: begin
            hi    <= f_hi;
            lo    <= f_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus corner sequences for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;
  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [W-1:0] SH = 32'h1111_1111;
  localparam logic [W-1:0] SL = 32'h2222_2222;
  logic clk = 0, rst = 0, start = 0, flush = 0, hi_sel = 0;
  logic [2:0] op = 3'd0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] rd;
  logic busy, done;
  int tests = 0, fails = 0;
  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_sel(hi_sel), .rd(rd), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    bit           div;
    string        name;
  } vec_t;
  vec_t v[13];
  task automatic add(input int i, input string n, input logic [2:0] o,
                     input logic [W-1:0] x, y, h, l);
    v[i].name = n; v[i].op = o; v[i].a = x; v[i].b = y; v[i].hi = h; v[i].lo = l;
    v[i].div = (o == OP_DIV) || (o == OP_DIVU);
  endtask
  task automatic chk(input string n, input logic [W-1:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rdhl(output logic [W-1:0] h, l);
    hi_sel = 1; #1 h = rd;
    hi_sel = 0; #1 l = rd;
  endtask
  task automatic mt(input logic [W-1:0] h, l);
    start = 1; op = OP_MTHI; a = h; tick;
    op = OP_MTLO; a = l; tick;
    start = 0;
  endtask
  task automatic run(input logic [2:0] o, input logic [W-1:0] x, y,
                     output int lat, output int bc);
    op = o; a = x; b = y; start = 1; tick;
    start = 0; lat = 0; bc = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) bc++;
      tick;
      if (done && lat == 0) lat = i;
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [W-1:0] h, l;
    int lat, bc, dn;
    bit act;
    add(0,  "mult_neg3x5",   OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    add(1,  "multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    add(2,  "mult_7x6",      OP_MULT,  32'd7,         32'd6,        32'h0,         32'h2A);
    add(3,  "mult_minxmin",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    add(4,  "mult_xneg1",    OP_MULT,  32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hEDCB_A988);
    add(5,  "multu_min2",    OP_MULTU, 32'h8000_0000, 32'd2,        32'h1,         32'h0);
    add(6,  "div_neg7by2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add(7,  "divu_by0",      OP_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF);
    add(8,  "div_ovf",       OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
    add(9,  "divu_100by7",   OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14);
    add(10, "div_7byneg2",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    add(11, "div_neg7by0",   OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
    add(12, "divu_maxby10",  OP_DIVU,  32'hFFFF_FFFF, 32'd10,       32'd5,         32'h1999_9999);
    repeat (2) @(posedge clk);
    #1;
    rdhl(h, l);
    chk("reset_hi", h, '0);
    chk("reset_lo", l, '0);
    chk("reset_busy", {31'b0, busy}, '0);
    chk("reset_done", {31'b0, done}, '0);
    rst = 1;
    tick;
    start = 1; op = OP_MTHI; a = 32'hCAFE_0001; tick;
    chk("mthi_busy", {31'b0, busy}, '0);
    op = OP_MTLO; a = 32'hCAFE_0002; tick;
    start = 0;
    chk("mtlo_done", {31'b0, done}, '0);
    rdhl(h, l);
    chk("mthi_val", h, 32'hCAFE_0001);
    chk("mtlo_val", l, 32'hCAFE_0002);
    for (int i = 0; i < 13; i++) begin
      act = !v[i].div || DIV_EN;
      mt(SH, SL);
      run(v[i].op, v[i].a, v[i].b, lat, bc);
      rdhl(h, l);
      chk($sformatf("%s_hi", v[i].name), h, act ? v[i].hi : SH);
      chk($sformatf("%s_lo", v[i].name), l, act ? v[i].lo : SL);
      chk($sformatf("%s_latency", v[i].name), lat, act ? 32'd33 : 32'd0);
      chk($sformatf("%s_busy_cycles", v[i].name), bc, act ? 32'd33 : 32'd0);
    end
    mt(SH, SL);
    op = OP_MULT; a = 32'd3; b = 32'd4; start = 1; tick;
    start = 0;
    repeat (4) tick;
    rdhl(h, l);
    chk("midop_hi", h, SH);
    chk("midop_lo", l, SL);
    op = OP_MTLO; a = 32'h0000_DEAD; start = 1; tick;
    op = OP_MULT; a = 32'd100; b = 32'd100; tick;
    start = 0; lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      tick;
      if (done) lat = i;
    end
    chk("ignored_start_latency", lat, 32'd27);
    rdhl(h, l);
    chk("ignored_start_hi", h, 32'd0);
    chk("ignored_start_lo", l, 32'd12);
    mt(SH, SL);
    op = OP_MULT; a = 32'd5; b = 32'd5; start = 1; tick;
    start = 0;
    repeat (9) tick;
    flush = 1; start = 1; a = 32'd9; b = 32'd9; tick;
    flush = 0; start = 0;
    chk("flush_busy", {31'b0, busy}, '0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done) dn++;
    end
    chk("flush_no_done", dn, 32'd0);
    rdhl(h, l);
    chk("flush_hi", h, SH);
    chk("flush_lo", l, SL);
    flush = 1; start = 1; op = OP_MTHI; a = 32'h0000_0BAD; tick;
    flush = 0; start = 0;
    rdhl(h, l);
    chk("flush_beats_mthi", h, SH);
    run(OP_MULTU, 32'h0001_0000, 32'h0001_0000, lat, bc);
    rdhl(h, l);
    chk("post_flush_hi", h, 32'h1);
    chk("post_flush_lo", l, 32'h0);
    chk("post_flush_latency", lat, 32'd33);
    mt(SH, SL);
    op = OP_MULT; a = 32'hFFFF_FFFD; b = 32'd5; start = 1; tick;
    start = 0;
    repeat (9) tick;
    op = OP_MTHI; a = 32'h0000_BEEF; start = 1; rst = 0;
    #1;
    rdhl(h, l);
    chk("async_rst_hi", h, '0);
    chk("async_rst_lo", l, '0);
    chk("async_rst_busy", {31'b0, busy}, '0);
    tick;
    rst = 1; start = 0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done) dn++;
    end
    chk("async_rst_no_done", dn, 32'd0);
    rdhl(h, l);
    chk("async_rst_hold_hi", h, '0);
    run(OP_MULT, 32'd7, 32'd6, lat, bc);
    rdhl(h, l);
    chk("after_rst_lo", l, 32'h2A);
    chk("after_rst_latency", lat, 32'd33);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
